branch_target_adder: RTL and testbench
======================================

Name: branch_target_adder

Overview:
- Computes the control-flow target address for one issued instruction: B-type branch, JAL, or JALR.
- Sits inside the branch functional unit.
- Provides a zero-latency combinational target for the same-cycle taken/not-taken mux, plus a one-cycle registered copy for debug and trace.
- Also produces the decoded immediate and an instruction-address-misaligned flag.

Parameters:
XLEN, 32, data/address width; immediates sign-extended to XLEN.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  issue packet valid this cycle
pc  input  XLEN  PC of the issued instruction
inst  input  32  raw instruction word
rs1_value  input  XLEN  rs1 operand, used as the JALR base
result  output  XLEN  combinational target address
imm  output  XLEN  combinational sign-extended immediate
is_ctrl  output  1  combinational; opcode is branch, JAL or JALR
misaligned  output  1  combinational target-misaligned flag
result_q  output  XLEN  registered result
misaligned_q  output  1  registered misaligned flag
valid_q  output  1  registered in_valid

Behaviour:
- Decode on inst[6:0]:
  - 1100011 (branch): imm = sext{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; base = pc; result = base + imm.
  - 1101111 (JAL): imm = sext{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; base = pc; result = base + imm.
  - 1100111 (JALR): imm = sext inst[31:20]; base = rs1_value; result = (base + imm) with bit 0 forced to 0.
  - Any other opcode: imm = 0, is_ctrl = 0, result = pc + 4.
- Arithmetic: modulo 2^XLEN; carry-out is discarded; wrap-around is legal and not flagged.
- Combinational outputs: depend only on pc, inst and rs1_value; in_valid does not gate them.
- misaligned: is_ctrl & (result[1:0] != 0), evaluated after the JALR bit-0 clear. Because bit 0 is cleared, only result[1] can trigger it. No compressed-ISA support.
- Registered stage, on each rising clock edge:
  - in_valid = 1: result_q <= result, misaligned_q <= misaligned, valid_q <= 1.
  - in_valid = 0: valid_q <= 0; result_q and misaligned_q hold their values.
- Latency: 0 cycles for the combinational outputs, 1 cycle for the registered outputs.
- Reset: reset = 0 immediately clears result_q, misaligned_q and valid_q to 0, regardless of clock. Reset mid-operation discards the in-flight value. The first capture after reset deassertion occurs on the next rising edge with in_valid = 1.
- No handshake and no backpressure; a new instruction may be presented every cycle.

Optional Feature:
BRANCH_TARGET_MISALIGN_CHECK_EN
- Defined: misaligned and misaligned_q behave as specified above.
- Undefined: misaligned is tied to 0 and misaligned_q stays 0.
- All other behaviour is identical in both builds.

Test Plan:
- Forward branch: inst=0x00208463 (beq x1,x2,+8), pc=0x00001000 -> result=0x00001008, imm=0x00000008, is_ctrl=1, misaligned=0.
- Backward branch: inst=0xFE000EE3 (beq x0,x0,-4), pc=0x00001000 -> imm=0xFFFFFFFC, result=0x00000FFC.
- JAL: inst=0x0100006F (jal x0,+16), pc=0x00002000 -> result=0x00002010, is_ctrl=1.
- JALR with bit-0 clear and misalignment:
  - inst=0x00508067 (jalr x0,5(x1)), rs1_value=0x00003000 -> result=0x00003004, misaligned=0.
  - Same inst, rs1_value=0x00003001 -> result=0x00003006, misaligned=1 (0 when the macro is undefined).
- Non-control and wrap-around:
  - inst=0x00000013 (addi), pc=0x00000100 -> result=0x00000104, imm=0, is_ctrl=0.
  - beq +8 at pc=0xFFFFFFFC -> result=0x00000004.
- Registered path and reset:
  - in_valid=1 with the forward-branch stimulus -> one edge later valid_q=1, result_q=0x00001008.
  - Next cycle in_valid=0 -> valid_q=0, result_q still 0x00001008.
  - Drive reset=0 between edges -> result_q=0, valid_q=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_target_adder.sv
// Control-flow target adder for the branch functional unit.
// Decodes the immediate of a B-type branch, JAL or JALR, forms the target
// address combinationally for the same-cycle taken/not-taken mux, and keeps
// a one-cycle registered copy for debug and trace.
// Optional feature: define BRANCH_TARGET_MISALIGN_CHECK_EN to enable the
// instruction-address-misaligned flag; otherwise misaligned and
// misaligned_q are held at 0.
module branch_target_adder #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_value,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] imm,
  output logic            is_ctrl,
  output logic            misaligned,
  output logic [XLEN-1:0] result_q,
  output logic            misaligned_q,
  output logic            valid_q
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Sign-extended immediates for each control-flow format.
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_i;

  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] addend;
  logic [XLEN-1:0] sum;
  logic            is_jalr;
  logic [XLEN-1:0] result_d;
  logic            misaligned_d;

  // Opcode decode: pick the base, addend and immediate for this instruction.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    base    = pc;
    addend  = XLEN'(4);
    imm     = '0;
    is_ctrl = 1'b0;
    is_jalr = 1'b0;
    unique case (inst[6:0])
      OPC_BRANCH: begin
        imm     = imm_b;
        addend  = imm_b;
        is_ctrl = 1'b1;
      end
      OPC_JAL: begin
        imm     = imm_j;
        addend  = imm_j;
        is_ctrl = 1'b1;
      end
      OPC_JALR: begin
        imm     = imm_i;
        addend  = imm_i;
        base    = rs1_value;
        is_ctrl = 1'b1;
        is_jalr = 1'b1;
      end
      default: ;
    endcase
  end

  // Modulo-2^XLEN add; carry-out is dropped and wrap-around is legal.
  assign sum = base + addend;

  // JALR clears bit 0 of the target before the alignment test.
  assign result_d = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
  assign result   = result_d;

`ifdef BRANCH_TARGET_MISALIGN_CHECK_EN
  // No compressed ISA: any target not on a 4-byte boundary is misaligned.
  assign misaligned_d = is_ctrl & (result_d[1:0] != 2'b00);
`else
  assign misaligned_d = 1'b0;
`endif
  assign misaligned = misaligned_d;

  // Trace register: capture on valid issue, hold otherwise; async clear.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!reset) begin
      result_q     <= '0;
      misaligned_q <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q     <= result_d;
        misaligned_q <= misaligned_d;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_adder.sv
// Self-checking bench for branch_target_adder: directed literal cases pin the
// reference model, then randomized issue packets are compared every cycle
// against the model for both combinational and registered outputs.
module tb_branch_target_adder;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] rs1_value;
  logic [31:0] result;
  logic [31:0] imm;
  logic        is_ctrl;
  logic        misaligned;
  logic [31:0] result_q;
  logic        misaligned_q;
  logic        valid_q;

  int n_checks = 0;
  int n_fail   = 0;

  branch_target_adder #(.XLEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .pc           (pc),
    .inst         (inst),
    .rs1_value    (rs1_value),
    .result       (result),
    .imm          (imm),
    .is_ctrl      (is_ctrl),
    .misaligned   (misaligned),
    .result_q     (result_q),
    .misaligned_q (misaligned_q),
    .valid_q      (valid_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef BRANCH_TARGET_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: target computed from the instruction-format rules with
  // plain signed integer arithmetic.
  function automatic void model(input logic [31:0] m_pc, input logic [31:0] m_inst,
                                input logic [31:0] m_rs1,
                                output logic [31:0] m_res, output logic [31:0] m_imm,
                                output logic m_ctrl, output logic m_mis);
    int signed   off;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [11:0] i12;
    m_ctrl = 1'b1;
    case (m_inst[6:0])
      7'h63: begin
        b13 = {m_inst[31], m_inst[7], m_inst[30:25], m_inst[11:8], 1'b0};
        off = int'(b13) - (b13[12] ? 8192 : 0);
        m_imm = 32'(off);
        m_res = m_pc + 32'(off);
      end
      7'h6F: begin
        j21 = {m_inst[31], m_inst[19:12], m_inst[20], m_inst[30:21], 1'b0};
        off = int'(j21) - (j21[20] ? (1 << 21) : 0);
        m_imm = 32'(off);
        m_res = m_pc + 32'(off);
      end
      7'h67: begin
        i12 = m_inst[31:20];
        off = int'(i12) - (i12[11] ? 4096 : 0);
        m_imm = 32'(off);
        m_res = (m_rs1 + 32'(off)) & 32'hFFFF_FFFE;
      end
      default: begin
        m_ctrl = 1'b0;
        m_imm  = 32'd0;
        m_res  = m_pc + 32'd4;
      end
    endcase
    m_mis = MIS_EN && m_ctrl && ((m_res % 4) != 0);
  endfunction

  // Model of the registered stage.
  logic [31:0] exp_res_q;
  logic        exp_mis_q;
  logic        exp_val_q;

  always @(posedge clock or negedge reset) begin
    logic [31:0] r, i;
    logic        c, m;
    if (!reset) begin
      exp_res_q <= 32'd0;
      exp_mis_q <= 1'b0;
      exp_val_q <= 1'b0;
    end else begin
      model(pc, inst, rs1_value, r, i, c, m);
      exp_val_q <= in_valid;
      if (in_valid) begin
        exp_res_q <= r;
        exp_mis_q <= m;
      end
    end
  end

  // Compare process: every falling edge outside reset, check all outputs.
  always @(negedge clock) begin
    logic [31:0] r, i;
    logic        c, m;
    if (reset) begin
      model(pc, inst, rs1_value, r, i, c, m);
      check("result",       result,               r);
      check("imm",          imm,                  i);
      check("is_ctrl",      32'(is_ctrl),         32'(c));
      check("misaligned",   32'(misaligned),      32'(m));
      check("result_q",     result_q,             exp_res_q);
      check("misaligned_q", 32'(misaligned_q),    32'(exp_mis_q));
      check("valid_q",      32'(valid_q),         32'(exp_val_q));
    end
  end

  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] in,
                       input logic [31:0] r1);
    in_valid  = v;
    pc        = p;
    inst      = in;
    rs1_value = r1;
  endtask

  initial begin
    logic [31:0] rinst;
    logic [6:0]  opc;
    reset = 1'b0;
    drive(1'b0, 32'h0, 32'h13, 32'h0);
    #3;
    check("reset_valid_q",  32'(valid_q), 32'd0);
    check("reset_result_q", result_q,     32'd0);
    @(posedge clock); #2;
    reset = 1'b1;

    // Directed literal expectations.
    @(posedge clock); #1;
    drive(1'b0, 32'h0000_1000, 32'h0020_8463, 32'h0); #1;
    check("fwd_result",  result,          32'h0000_1008);
    check("fwd_imm",     imm,             32'h0000_0008);
    check("fwd_is_ctrl", 32'(is_ctrl),    32'd1);
    check("fwd_mis",     32'(misaligned), 32'd0);

    drive(1'b0, 32'h0000_1000, 32'hFE00_0EE3, 32'h0); #1;
    check("bwd_imm",    imm,    32'hFFFF_FFFC);
    check("bwd_result", result, 32'h0000_0FFC);

    drive(1'b0, 32'h0000_2000, 32'h0100_006F, 32'h0); #1;
    check("jal_result",  result,       32'h0000_2010);
    check("jal_is_ctrl", 32'(is_ctrl), 32'd1);

    drive(1'b0, 32'h0, 32'h0050_8067, 32'h0000_3000); #1;
    check("jalr_result", result,          32'h0000_3004);
    check("jalr_mis",    32'(misaligned), 32'd0);

    drive(1'b0, 32'h0, 32'h0050_8067, 32'h0000_3001); #1;
    check("jalr_odd_result", result,          32'h0000_3006);
    check("jalr_odd_mis",    32'(misaligned), MIS_EN ? 32'd1 : 32'd0);

    drive(1'b0, 32'h0000_0100, 32'h0000_0013, 32'h0); #1;
    check("addi_result",  result,       32'h0000_0104);
    check("addi_imm",     imm,          32'h0);
    check("addi_is_ctrl", 32'(is_ctrl), 32'd0);

    drive(1'b0, 32'hFFFF_FFFC, 32'h0020_8463, 32'h0); #1;
    check("wrap_result", result, 32'h0000_0004);

    // Registered path: capture, hold, then asynchronous clear.
    drive(1'b1, 32'h0000_1000, 32'h0020_8463, 32'h0);
    @(posedge clock); #1;
    check("reg_valid_q",  32'(valid_q), 32'd1);
    check("reg_result_q", result_q,     32'h0000_1008);
    drive(1'b0, 32'h0000_0100, 32'h0000_0013, 32'h0);
    @(posedge clock); #1;
    check("hold_valid_q",  32'(valid_q), 32'd0);
    check("hold_result_q", result_q,     32'h0000_1008);
    drive(1'b1, 32'h0000_0100, 32'h0050_8067, 32'h0000_3001);
    @(posedge clock); #1;
    check("cap2_result_q",     result_q,          32'h0000_3006);
    check("cap2_misaligned_q", 32'(misaligned_q), MIS_EN ? 32'd1 : 32'd0);
    #1 reset = 1'b0;
    #1;
    check("async_result_q",     result_q,          32'd0);
    check("async_valid_q",      32'(valid_q),      32'd0);
    check("async_misaligned_q", 32'(misaligned_q), 32'd0);
    @(negedge clock); #2;
    reset = 1'b1;

    // Randomized issue stream.
    for (int n = 0; n < 400; n++) begin
      @(posedge clock); #1;
      rinst = $urandom;
      case ($urandom_range(0, 3))
        0: opc = 7'h63;
        1: opc = 7'h6F;
        2: opc = 7'h67;
        default: opc = 7'($urandom);
      endcase
      rinst[6:0] = opc;
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? (32'hFFFF_F000 | 32'($urandom_range(0, 4095)))
                                        : 32'($urandom),
            rinst, 32'($urandom));
    end
    @(posedge clock); #1;
    drive(1'b0, 32'h0, 32'h13, 32'h0);
    @(negedge clock); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
